lcd_bus_sequencer: RTL and testbench
====================================

// Module: lcd_bus_sequencer
// PURPOSE
// - Owns the IO-bus LCD path: queues CPU command/data bytes and replays them to the character LCD with correct E/RS/RnW timing.
// - Sits between io_control output decode and display_lcd; the CPU writes at full bus speed, and this block absorbs the slow LCD timing.
// - Reports queue state and sticky error flags back to the CPU.
// PARAMETERS
// - FIFO_DEPTH  4    queue entries; power of 2, >=2
// - SETUP_CYC   1    clk cycles RS/RnW/data stable before E rises (>=1)
// - PULSE_CYC   4    clk cycles E held high (>=1)
// - HOLD_CYC    1    clk cycles data/RS held after E falls (>=1)
// - EXEC_CYC    40   fixed post-write wait; used only when busy polling is compiled out
// - POLL_LIMIT  255  max busy-flag reads per byte before timeout (1..255)
// PORTS
// - clk          in   1  system clock; every flop is on posedge clk
// - reset        in   1  synchronous, active-high; flushes queue, returns FSM to IDLE
// - wr_en        in   1  enqueue strobe, one entry per cycle high
// - wr_rs        in   1  0 = command byte, 1 = data byte
// - wr_data      in   8  byte to enqueue
// - clr_err      in   1  clears the ovf and tmo flags
// - full         out  1  queue holds FIFO_DEPTH entries
// - busy         out  1  FSM not IDLE, or queue not empty
// - ovf          out  1  sticky: a write was dropped
// - tmo          out  1  sticky: POLL_LIMIT was exhausted
// - lcd_e        out  1  LCD enable strobe
// - lcd_rs       out  1  LCD register select
// - lcd_rnw      out  1  1 = LCD read
// - lcd_db_out   out  8  data driven to the LCD
// - lcd_db_oe    out  1  1 = drive lcd_db_out onto io_bus
// - lcd_db_in    in   8  LCD read-back; bit 7 = busy flag
// BEHAVIOUR
// - Reset values: all outputs 0, queue empty, poll counter 0.
// - Enqueue: on wr_en && !full, push {wr_rs, wr_data}.
//   - wr_en while full: accepted if the FSM pops in the same cycle; otherwise dropped and ovf is set.
// - Pointers wrap modulo FIFO_DEPTH; occupancy counter is $clog2(FIFO_DEPTH)+1 bits wide.
// - States and transitions (the stated cycle counts are exact):
//   - IDLE: wait for a non-empty queue; pop the head. Latency from the push edge to SETUP is 1 cycle.
//   - W_SETUP: SETUP_CYC cycles; rs = entry rs, rnw = 0, db_out = entry data, oe = 1, e = 0.
//   - W_PULSE: PULSE_CYC cycles; e = 1, other signals unchanged.
//   - W_HOLD: HOLD_CYC cycles; e = 0, data still driven. Exit goes to R_SETUP (polling) or WAIT.
//   - R_SETUP: SETUP_CYC cycles; rs = 0, rnw = 1, oe = 0.
//   - R_PULSE: PULSE_CYC cycles; e = 1. lcd_db_in[7] is sampled on the last pulse cycle.
//   - R_HOLD: HOLD_CYC cycles; e = 0. Poll counter increments.
//     - sampled busy = 0: go to IDLE.
//     - busy = 1 and count < POLL_LIMIT: go to R_SETUP.
//     - busy = 1 and count = POLL_LIMIT: set tmo and go to IDLE.
//   - WAIT: EXEC_CYC cycles with all LCD outputs 0, then go to IDLE.
// - Edge rules:
//   - lcd_e never rises in the same cycle that rs, rnw or db_out change.
//   - oe and rnw are never both 1.
// - Reset mid-transfer: on the next edge e = 0 and oe = 0; the queued entries and the in-flight byte are discarded.
// - clr_err and a new error in the same cycle: the flag ends up set.
// CONFIGURATION
// - LCD_BUSY_POLL_EN defined: after W_HOLD, the R_* states poll the busy flag; EXEC_CYC is unused.
// - LCD_BUSY_POLL_EN undefined: after W_HOLD, the FSM goes to WAIT; the R_* states, tmo logic and poll counter are removed; tmo is tied to 0.
// STRUCTURE
// - Shared header io_defs.vh holds:
//   - FSM state encodings
//   - LCD_BUSY_BIT = 7
//   - the queue entry width (9)
// - One sub-module, lcd_cmd_fifo: a synchronous FIFO with parameter DEPTH and ports push/pop/full/empty.
// - The sequencer keeps the FSM, a single shared phase counter, the poll counter and the error flags.
// TESTING
// - Write cmd 0x38: E is high for exactly 4 cycles, beginning SETUP_CYC cycles after the pop; rs = 0, db = 0x38 throughout.
// - Write 5 bytes back-to-back with the FSM stalled on the first: 4 are queued, the 5th sets ovf, full = 1; clr_err clears ovf.
// - With polling, hold lcd_db_in = 0x80 for 3 reads, then 0x00: exactly 4 read pulses, then IDLE, tmo = 0.
// - With polling and lcd_db_in = 0x80 forever, POLL_LIMIT = 3: 3 reads, then tmo = 1 and the next queued byte proceeds.
// - Without polling: data 0x41 completes, then 40 idle cycles pass before the next E rise.
// - Assert reset during W_PULSE: e = 0 next cycle, busy = 0, full = 0, and no further E pulses occur.

Source files
------------

// File: rtl/lcd_bus_sequencer_pkg.sv
// Shared definitions for the LCD bus sequencer: FSM state encodings, queue
// entry layout, busy-flag bit position and the phase-counter helper.
package lcd_bus_sequencer_pkg;

  localparam int ENTRY_W      = 9;
  localparam int LCD_BUSY_BIT = 7;
  localparam int PHASE_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_SETUP,
    ST_W_PULSE,
    ST_W_HOLD,
    ST_R_SETUP,
    ST_R_PULSE,
    ST_R_HOLD,
    ST_WAIT
  } state_t;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } entry_t;

  // True on the last cycle of a phase that lasts 'cycles' clocks.
  function automatic logic phase_done(input logic [PHASE_W-1:0] phase,
                                      input int cycles);
    return phase == PHASE_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/lcd_bus_sequencer_fifo.sv
// lcd_cmd_fifo: synchronous FIFO holding {rs, data} entries for the LCD
// sequencer. A push while full is accepted when a pop happens in the same cycle.
module lcd_cmd_fifo
  import lcd_bus_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ENTRY_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Entry storage.
  // NOTE: the array has no reset; occupancy is tracked by count, so stale
  // contents are never observed and the storage can map to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; power-of-2 depth lets the pointers wrap naturally.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lcd_bus_sequencer.sv
// lcd_bus_sequencer: queues CPU command/data bytes and replays them to a
// character LCD with E/RS/RnW timing. Define LCD_BUSY_POLL_EN to poll the
// LCD busy flag after each write; otherwise a fixed EXEC_CYC wait is used.
module lcd_bus_sequencer
  import lcd_bus_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SETUP_CYC  = 1,
  parameter int PULSE_CYC  = 4,
  parameter int HOLD_CYC   = 1,
  parameter int EXEC_CYC   = 40,
  parameter int POLL_LIMIT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  input  logic       clr_err,
  output logic       full,
  output logic       busy,
  output logic       ovf,
  output logic       tmo,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rnw,
  output logic [7:0] lcd_db_out,
  output logic       lcd_db_oe,
  input  logic [7:0] lcd_db_in
);

  state_t             state;
  logic [PHASE_W-1:0] phase;
  logic [ENTRY_W-1:0] fifo_dout;
  entry_t             head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               unused_db_bits;

`ifdef LCD_BUSY_POLL_EN
  logic [7:0] poll_cnt;
  logic       busy_flag;
  localparam int unused_exec_cyc = EXEC_CYC;
`else
  localparam int unused_poll_limit = POLL_LIMIT;
  assign tmo = 1'b0;
`endif

  assign pop            = (state == ST_IDLE) && !fifo_empty;
  assign head           = entry_t'(fifo_dout);
  assign full           = fifo_full;
  assign busy           = (state != ST_IDLE) || !fifo_empty;
  assign unused_db_bits = ^lcd_db_in;

  lcd_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_en),
    .pop   (pop),
    .din   ({wr_rs, wr_data}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sticky overflow: a write meeting a full queue without a same-cycle pop is lost.
  always_ff @(posedge clk) begin
    if (reset) ovf <= 1'b0;
    else       ovf <= (ovf && !clr_err) || (wr_en && fifo_full && !pop);
  end

  // Bus sequencer: one state per bus phase, a shared phase counter, registered pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      phase      <= '0;
      lcd_e      <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_rnw    <= 1'b0;
      lcd_db_out <= '0;
      lcd_db_oe  <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
      poll_cnt   <= '0;
      busy_flag  <= 1'b0;
      tmo        <= 1'b0;
`endif
    end else begin
`ifdef LCD_BUSY_POLL_EN
      // NOTE: the later non-blocking write in ST_R_HOLD wins, so a timeout in
      // the same cycle as clr_err leaves tmo set.
      if (clr_err) tmo <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (pop) begin
            state      <= ST_W_SETUP;
            phase      <= '0;
            lcd_rs     <= head.rs;
            lcd_rnw    <= 1'b0;
            lcd_db_out <= head.data;
            lcd_db_oe  <= 1'b1;
`ifdef LCD_BUSY_POLL_EN
            poll_cnt   <= '0;
`endif
          end
        end
        ST_W_SETUP: begin
          if (phase_done(phase, SETUP_CYC)) begin
            state <= ST_W_PULSE;
            phase <= '0;
            lcd_e <= 1'b1;
          end else phase <= phase + 1'b1;
        end
        ST_W_PULSE: begin
          if (phase_done(phase, PULSE_CYC)) begin
            state <= ST_W_HOLD;
            phase <= '0;
            lcd_e <= 1'b0;
          end else phase <= phase + 1'b1;
        end
        ST_W_HOLD: begin
          if (phase_done(phase, HOLD_CYC)) begin
            phase      <= '0;
            lcd_rs     <= 1'b0;
            lcd_db_out <= '0;
            lcd_db_oe  <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
            state      <= ST_R_SETUP;
            lcd_rnw    <= 1'b1;
`else
            state      <= ST_WAIT;
`endif
          end else phase <= phase + 1'b1;
        end
`ifdef LCD_BUSY_POLL_EN
        ST_R_SETUP: begin
          if (phase_done(phase, SETUP_CYC)) begin
            state <= ST_R_PULSE;
            phase <= '0;
            lcd_e <= 1'b1;
          end else phase <= phase + 1'b1;
        end
        ST_R_PULSE: begin
          if (phase_done(phase, PULSE_CYC)) begin
            state     <= ST_R_HOLD;
            phase     <= '0;
            lcd_e     <= 1'b0;
            busy_flag <= lcd_db_in[LCD_BUSY_BIT];
          end else phase <= phase + 1'b1;
        end
        ST_R_HOLD: begin
          if (phase_done(phase, HOLD_CYC)) begin
            phase    <= '0;
            poll_cnt <= poll_cnt + 8'd1;
            if (busy_flag && ((poll_cnt + 8'd1) < 8'(POLL_LIMIT))) begin
              state <= ST_R_SETUP;
            end else begin
              state   <= ST_IDLE;
              lcd_rnw <= 1'b0;
              if (busy_flag) tmo <= 1'b1;
            end
          end else phase <= phase + 1'b1;
        end
`endif
        ST_WAIT: begin
          if (phase_done(phase, EXEC_CYC)) begin
            state <= ST_IDLE;
            phase <= '0;
          end else phase <= phase + 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          phase <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Self-checking bench for lcd_bus_sequencer. Expected LCD pulses are queued
// when bytes are written; a negedge monitor measures each E pulse and compares
// it against the queue head. Polling scenarios build with LCD_BUSY_POLL_EN.
module tb_lcd_bus_sequencer;

  // Write pulse -> next write pulse gap (E-low cycles) and the wait from the
  // second cycle after a write pulse ends until the FSM is back in IDLE.
`ifdef LCD_BUSY_POLL_EN
  localparam int NEXT_GAP    = 3;   // R_HOLD + IDLE + W_SETUP
  localparam int ACCEPT_WAIT = 6;   // R_PULSE x4 + R_HOLD + 1 into IDLE
`else
  localparam int NEXT_GAP    = 43;  // W_HOLD + WAIT x40 + IDLE + W_SETUP
  localparam int ACCEPT_WAIT = 40;  // WAIT x40, ending in IDLE
`endif

  typedef struct {
    logic       rs;
    logic       rnw;
    logic       oe;
    logic [7:0] db;
    int         len;
    int         gap;
  } pulse_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic       wr_rs;
  logic [7:0] wr_data;
  logic       clr_err;
  logic       full;
  logic       busy;
  logic       ovf;
  logic       tmo;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rnw;
  logic [7:0] lcd_db_out;
  logic       lcd_db_oe;
  logic [7:0] lcd_db_in;

  pulse_t exp_q[$];
  int     n_checks   = 0;
  int     n_errors   = 0;
  int     busy_reads = 0;
  int     read_count = 0;
  int     rise_count = 0;

  lcd_bus_sequencer #(
    .FIFO_DEPTH (4),
    .SETUP_CYC  (1),
    .PULSE_CYC  (4),
    .HOLD_CYC   (1),
    .EXEC_CYC   (40),
    .POLL_LIMIT (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_rs      (wr_rs),
    .wr_data    (wr_data),
    .clr_err    (clr_err),
    .full       (full),
    .busy       (busy),
    .ovf        (ovf),
    .tmo        (tmo),
    .lcd_e      (lcd_e),
    .lcd_rs     (lcd_rs),
    .lcd_rnw    (lcd_rnw),
    .lcd_db_out (lcd_db_out),
    .lcd_db_oe  (lcd_db_oe),
    .lcd_db_in  (lcd_db_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic rs, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_rs   = rs;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic expect_read(input int gap);
    pulse_t p;
    p = '{rs: 1'b0, rnw: 1'b1, oe: 1'b0, db: 8'h00, len: 4, gap: gap};
    exp_q.push_back(p);
  endtask

  // A write pulse; with polling it is always followed by at least one read.
  task automatic expect_write(input logic rs, input logic [7:0] d, input int gap);
    pulse_t p;
    p = '{rs: rs, rnw: 1'b0, oe: 1'b1, db: d, len: 4, gap: gap};
    exp_q.push_back(p);
`ifdef LCD_BUSY_POLL_EN
    expect_read(2);
`endif
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc && !(busy == 1'b0 && lcd_e == 1'b0); i++) step();
    check("idle_reached", busy, 0);
  endtask

  task automatic wait_e(input logic v, input int max_cyc);
    for (int i = 0; i < max_cyc && lcd_e !== v; i++) step();
    check("e_reached", lcd_e, v);
  endtask

  // Monitor and LCD model: measures every E pulse and answers reads.
  logic [10:0] sig;
  logic [10:0] prev_sig = '0;
  logic        e_prev   = 1'b0;
  logic        setup_bad;
  logic        hold_bad;
  logic        exp_ok;
  int          high_cnt = 0;
  int          low_cnt  = -1;
  pulse_t      got;
  pulse_t      exp_p;

  always @(negedge clk) begin
    sig = {lcd_rs, lcd_rnw, lcd_db_oe, lcd_db_out};
    if (reset) begin
      e_prev  = 1'b0;
      low_cnt = -1;
    end else begin
      if (lcd_e && !e_prev) begin
        rise_count++;
        got.rs    = lcd_rs;
        got.rnw   = lcd_rnw;
        got.oe    = lcd_db_oe;
        got.db    = lcd_db_out;
        got.gap   = low_cnt;
        setup_bad = (sig != prev_sig);
        hold_bad  = 1'b0;
        high_cnt  = 1;
        if (lcd_rnw) begin
          read_count++;
          lcd_db_in = (read_count <= busy_reads) ? 8'h80 : 8'h00;
        end
      end else if (lcd_e) begin
        high_cnt++;
        if (sig != prev_sig) hold_bad = 1'b1;
      end else if (e_prev) begin
        got.len = high_cnt;
        exp_ok  = (exp_q.size() != 0);
        check("pulse_expected", exp_ok, 1);
        if (exp_ok) begin
          exp_p = exp_q.pop_front();
          check("pulse_rs", got.rs, exp_p.rs);
          check("pulse_rnw", got.rnw, exp_p.rnw);
          check("pulse_oe", got.oe, exp_p.oe);
          check("pulse_db", got.db, exp_p.db);
          check("pulse_len", got.len, exp_p.len);
          if (exp_p.gap >= 0) check("pulse_gap", got.gap, exp_p.gap);
          check("pulse_setup_stable", setup_bad, 0);
          check("pulse_hold_stable", hold_bad, 0);
          check("pulse_oe_rnw_excl", got.oe & got.rnw, 0);
        end
        low_cnt = 1;
      end else if (low_cnt >= 0) begin
        low_cnt++;
      end
      e_prev = lcd_e;
    end
    prev_sig = sig;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rc;
    reset     = 1'b1;
    wr_en     = 1'b0;
    wr_rs     = 1'b0;
    wr_data   = 8'h00;
    clr_err   = 1'b0;
    lcd_db_in = 8'h00;
    repeat (3) step();

    // Reset state
    check("rst_e", lcd_e, 0);
    check("rst_rs", lcd_rs, 0);
    check("rst_rnw", lcd_rnw, 0);
    check("rst_db_out", lcd_db_out, 0);
    check("rst_oe", lcd_db_oe, 0);
    check("rst_full", full, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_tmo", tmo, 0);
    reset = 1'b0;
    step();

    // Command 0x38: push edge, pop into W_SETUP one cycle later, E rises next
    expect_write(1'b0, 8'h38, -1);
    write_byte(1'b0, 8'h38);
    check("lat_busy", busy, 1);
    check("lat_idle_e", lcd_e, 0);
    check("lat_idle_oe", lcd_db_oe, 0);
    step();
    check("setup_oe", lcd_db_oe, 1);
    check("setup_e", lcd_e, 0);
    check("setup_db", lcd_db_out, 8'h38);
    check("setup_rs", lcd_rs, 0);
    step();
    check("pulse_e_high", lcd_e, 1);
    wait_idle(300);

    // Overflow: one byte in flight, four queued, fifth dropped
    expect_write(1'b1, 8'h01, -1);
    expect_write(1'b1, 8'h41, NEXT_GAP);
    expect_write(1'b0, 8'h02, NEXT_GAP);
    expect_write(1'b0, 8'h03, NEXT_GAP);
    expect_write(1'b0, 8'h04, NEXT_GAP);
    write_byte(1'b1, 8'h01);
    write_byte(1'b1, 8'h41);
    write_byte(1'b0, 8'h02);
    write_byte(1'b0, 8'h03);
    write_byte(1'b0, 8'h04);
    write_byte(1'b0, 8'h05);
    check("ovf_full", full, 1);
    check("ovf_set", ovf, 1);
    clr_err = 1'b1;
    write_byte(1'b0, 8'h06);
    clr_err = 1'b0;
    check("ovf_clr_and_drop", ovf, 1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("ovf_cleared", ovf, 0);
    check("ovf_still_full", full, 1);

    // Write while full in the cycle the FSM pops: accepted, no overflow
    repeat (ACCEPT_WAIT) step();
    expect_write(1'b1, 8'h47, NEXT_GAP);
    write_byte(1'b1, 8'h47);
    check("swap_full", full, 1);
    check("swap_no_ovf", ovf, 0);
    wait_idle(600);

    // Reset during W_PULSE: transfer and queue discarded
    expect_write(1'b0, 8'h55, -1);
    write_byte(1'b0, 8'h55);
    write_byte(1'b0, 8'h66);
    write_byte(1'b0, 8'h77);
    wait_e(1'b1, 20);
    reset = 1'b1;
    exp_q.delete();
    step();
    check("rst_mid_e", lcd_e, 0);
    check("rst_mid_oe", lcd_db_oe, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_full", full, 0);
    reset = 1'b0;
    rc = rise_count;
    repeat (150) step();
    check("rst_mid_no_pulse", rise_count, rc);

    // Recovery after reset
    expect_write(1'b0, 8'h0C, -1);
    write_byte(1'b0, 8'h0C);
    wait_idle(200);

`ifdef LCD_BUSY_POLL_EN
    // Busy for two reads, free on the third (= POLL_LIMIT): no timeout
    busy_reads = 2;
    read_count = 0;
    expect_write(1'b0, 8'h01, -1);
    expect_read(2);
    expect_read(2);
    write_byte(1'b0, 8'h01);
    wait_idle(200);
    check("poll_tmo_clear", tmo, 0);

    // Busy forever: three reads per byte, timeout, next byte still runs
    busy_reads = 1000;
    read_count = 0;
    expect_write(1'b0, 8'h02, -1);
    expect_read(2);
    expect_read(2);
    expect_write(1'b0, 8'h03, 3);
    expect_read(2);
    expect_read(2);
    write_byte(1'b0, 8'h02);
    write_byte(1'b0, 8'h03);
    wait_idle(300);
    check("poll_tmo_set", tmo, 1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("poll_tmo_cleared", tmo, 0);
`endif

    repeat (5) step();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
